tx_frame_sequencer: RTL and testbench

//  Frame-level controller for the 802.11a Transmitter datapath (Start/Input/Output, one bit per Clock).
//  - Accepts a PSDU length request and pulses Start.
//  - Waits out the preamble/SIGNAL latency, then drives the serial DATA field into Input:

---
 rtl/tx_frame_sequencer_if.sv | 35 +++
 rtl/tx_frame_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tx_frame_sequencer_if
// Brief    : MAC request, upstream payload and transmitter-control bundle.
// Revision : 1.0
// ============================================================================
interface tx_frame_sequencer_if #(
  parameter int LEN_WIDTH = 12,
  parameter int SYM_WIDTH = 16
);
  logic                 Req_Valid;
  logic [LEN_WIDTH-1:0] Req_Length;
  logic                 Req_Ready;
  logic                 Bit_Valid;
  logic                 Bit_Data;
  logic                 Bit_Ready;
  logic                 Tx_Start;
  logic                 Tx_Input;
  logic                 Busy;
  logic                 Done;
  logic                 Underrun;
  logic [SYM_WIDTH-1:0] Symbol_Count;

  modport master (
    output Req_Valid, Req_Length, Bit_Valid, Bit_Data,
    input  Req_Ready, Bit_Ready, Tx_Start, Tx_Input, Busy, Done, Underrun, Symbol_Count
  );

  modport slave (
    input  Req_Valid, Req_Length, Bit_Valid, Bit_Data,
    output Req_Ready, Bit_Ready, Tx_Start, Tx_Input, Busy, Done, Underrun, Symbol_Count
  );
endinterface
`default_nettype wire

// File: rtl/tx_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tx_frame_sequencer
// Brief    : 802.11a frame controller: Start pulse, preamble wait, then the
//            serial DATA field (SERVICE, payload, TAIL, pad) one bit per clock.
//            Optional macro TX_UNDERRUN_ABORT_EN aborts the frame on underrun.
// Revision : 1.0
// ============================================================================
module tx_frame_sequencer #(
  parameter int PREAMBLE_CYCLES = 137,
  parameter int N_DBPS          = 24,
  parameter int LEN_WIDTH       = 12,
  parameter int SYM_WIDTH       = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  tx_frame_sequencer_if.slave bus
);

  localparam int c_BITS_W = LEN_WIDTH + 3;
  localparam int c_PRE_W  = $clog2(PREAMBLE_CYCLES + 1);
  localparam int c_CNT_W  = (c_BITS_W > c_PRE_W) ? c_BITS_W : c_PRE_W;
  localparam int c_SB_W   = $clog2(N_DBPS + 1);

  localparam logic [c_CNT_W-1:0]   c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]   c_WAIT_LOAD    = c_CNT_W'(PREAMBLE_CYCLES - 2);
  localparam logic [c_CNT_W-1:0]   c_SERVICE_LOAD = c_CNT_W'(15);
  localparam logic [c_CNT_W-1:0]   c_TAIL_LOAD    = c_CNT_W'(5);
  localparam logic [c_SB_W-1:0]    c_SB_LAST      = c_SB_W'(N_DBPS - 1);
  localparam logic [c_SB_W-1:0]    c_SB_ONE       = c_SB_W'(1);
  localparam logic [SYM_WIDTH-1:0] c_SYM_ONE      = SYM_WIDTH'(1);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_START   = 3'd1;
  localparam logic [2:0] c_ST_WAIT    = 3'd2;
  localparam logic [2:0] c_ST_SERVICE = 3'd3;
  localparam logic [2:0] c_ST_PAYLOAD = 3'd4;
  localparam logic [2:0] c_ST_TAIL    = 3'd5;
  localparam logic [2:0] c_ST_PAD     = 3'd6;
  localparam logic [2:0] c_ST_DONE    = 3'd7;

  // r_state names what Tx_Input is showing this cycle; outputs are registered
  // from w_next so each phase appears on the pins exactly when its state is live.
  logic [2:0]           r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_BITS_W-1:0]  r_len_bits;
  logic [c_SB_W-1:0]    r_sym_bit;
  logic [SYM_WIDTH-1:0] r_sym_count;
  logic                 r_tx_start;
  logic                 r_tx_input;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_underrun;

  logic [2:0]           w_next_base;
  logic [2:0]           w_next;
  logic [c_CNT_W-1:0]   w_cnt_next;
  logic                 w_in_data;
  logic                 w_sym_wrap;
  logic                 w_take;
  logic                 w_starve;
  logic                 w_accept;

  assign w_in_data  = (r_state == c_ST_SERVICE) || (r_state == c_ST_PAYLOAD) ||
                      (r_state == c_ST_TAIL)    || (r_state == c_ST_PAD);
  assign w_sym_wrap = w_in_data && (r_sym_bit == c_SB_LAST);
  assign w_accept   = (r_state == c_ST_IDLE) && bus.Req_Valid;

  always_comb begin
    w_next_base = r_state;
    w_cnt_next  = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.Req_Valid) w_next_base = c_ST_START;
      end
      c_ST_START: begin
        w_next_base = c_ST_WAIT;
        w_cnt_next  = c_WAIT_LOAD;
      end
      c_ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next_base = c_ST_SERVICE;
          w_cnt_next  = c_SERVICE_LOAD;
        end else begin
          w_cnt_next  = r_cnt - c_CNT_ONE;
        end
      end
      c_ST_SERVICE: begin
        if (r_cnt != '0) begin
          w_cnt_next  = r_cnt - c_CNT_ONE;
        end else if (r_len_bits == '0) begin
          w_next_base = c_ST_TAIL;
          w_cnt_next  = c_TAIL_LOAD;
        end else begin
          w_next_base = c_ST_PAYLOAD;
          w_cnt_next  = c_CNT_W'(r_len_bits) - c_CNT_ONE;
        end
      end
      c_ST_PAYLOAD: begin
        if (r_cnt == '0) begin
          w_next_base = c_ST_TAIL;
          w_cnt_next  = c_TAIL_LOAD;
        end else begin
          w_cnt_next  = r_cnt - c_CNT_ONE;
        end
      end
      c_ST_TAIL: begin
        if (r_cnt == '0) begin
          w_next_base = w_sym_wrap ? c_ST_DONE : c_ST_PAD;
        end else begin
          w_cnt_next  = r_cnt - c_CNT_ONE;
        end
      end
      c_ST_PAD: begin
        if (w_sym_wrap) w_next_base = c_ST_DONE;
      end
      c_ST_DONE: begin
        w_next_base = c_ST_IDLE;
      end
      default: begin
        w_next_base = c_ST_IDLE;
      end
    endcase
  end

  // A payload bit is consumed on the edge that enters a PAYLOAD cycle.
  assign w_take   = (w_next_base == c_ST_PAYLOAD);
  assign w_starve = w_take && !bus.Bit_Valid;

`ifdef TX_UNDERRUN_ABORT_EN
  assign w_next = w_starve ? c_ST_IDLE : w_next_base;
`else
  assign w_next = w_next_base;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_len_bits  <= '0;
      r_sym_bit   <= '0;
      r_sym_count <= '0;
      r_tx_start  <= 1'b0;
      r_tx_input  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_tx_start <= (w_next == c_ST_START);
      r_tx_input <= w_take && bus.Bit_Valid && bus.Bit_Data;
      r_done     <= (w_next == c_ST_DONE);
      r_busy     <= (w_next != c_ST_IDLE) && (w_next != c_ST_DONE);
      if (w_accept) begin
        r_len_bits  <= {bus.Req_Length, 3'b000};
        r_underrun  <= 1'b0;
        r_sym_count <= '0;
        r_sym_bit   <= '0;
      end else begin
        if (w_starve) r_underrun <= 1'b1;
        if (w_sym_wrap) begin
          r_sym_bit   <= '0;
          r_sym_count <= r_sym_count + c_SYM_ONE;
        end else if (w_in_data) begin
          r_sym_bit   <= r_sym_bit + c_SB_ONE;
        end
      end
    end
  end

  assign bus.Req_Ready    = (r_state == c_ST_IDLE);
  assign bus.Bit_Ready    = w_take;
  assign bus.Tx_Start     = r_tx_start;
  assign bus.Tx_Input     = r_tx_input;
  assign bus.Busy         = r_busy;
  assign bus.Done         = r_done;
  assign bus.Underrun     = r_underrun;
  assign bus.Symbol_Count = r_sym_count;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tx_frame_sequencer
// Brief    : Self-checking bench for tx_frame_sequencer (vector table plus
//            reset-abort and back-to-back sequences).
// Revision : 1.0
// ============================================================================
module tb_tx_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_frame_sequencer_if #(.LEN_WIDTH(12), .SYM_WIDTH(16)) bus ();

  tx_frame_sequencer #(
    .PREAMBLE_CYCLES(137),
    .N_DBPS         (24),
    .LEN_WIDTH      (12),
    .SYM_WIDTH      (16)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          len;
    logic [63:0] pl;
    int          drop;
    int          exp_sym;
    int          exp_total;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle k is counted from the accept cycle (k=0); DATA field starts at k=138.
  function automatic int exp_bit(input vec_t v, input int k);
    int o;
    o = k - 154;
    if (o >= 0 && o < 8 * v.len) begin
      if (o == v.drop) return 0;
`ifdef TX_UNDERRUN_ABORT_EN
      if (v.drop >= 0 && o > v.drop) return 0;
`endif
      return int'(v.pl[63 - o]);
    end
    return 0;
  endfunction

  task automatic run_frame(input int id, input vec_t v);
    int start_cnt = 0, start_k = -1, done_cnt = 0, done_k = -1;
    int bad_bits = 0, bad_busy = 0, bit_cnt = 0;
    int exp_done, exp_end, exp_sym;
    int sym_end = -1, unr_end = -1, rdy_end = -1;
    int w = 0;
    exp_done = 138 + v.exp_total;
    exp_end  = exp_done;
    exp_sym  = v.exp_sym;
`ifdef TX_UNDERRUN_ABORT_EN
    if (v.drop >= 0) begin
      exp_done = -1;
      exp_end  = 154 + v.drop;
      exp_sym  = (16 + v.drop) / 24;
    end
`endif
    while (!bus.Req_Ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("v%0d req_ready_before", id), int'(bus.Req_Ready), 1);
    bus.Req_Valid  = 1'b1;
    bus.Req_Length = 12'(v.len);
    for (int k = 1; k <= exp_end + 2; k++) begin
      @(negedge clk);
      if (k == 1) bus.Req_Valid = 1'b0;
      if (bus.Tx_Start) begin start_cnt++; start_k = k; end
      if (bus.Done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (int'(bus.Tx_Input) != exp_bit(v, k)) bad_bits++;
      if (k <= exp_end && int'(bus.Busy) != ((k < exp_end) ? 1 : 0)) bad_busy++;
      if (k == exp_end) begin
        sym_end = int'(bus.Symbol_Count);
        unr_end = int'(bus.Underrun);
        rdy_end = int'(bus.Req_Ready);
      end
      if (bus.Bit_Ready) begin
        bus.Bit_Valid = (bit_cnt != v.drop);
        bus.Bit_Data  = v.pl[63 - bit_cnt];
        bit_cnt++;
      end else begin
        bus.Bit_Valid = 1'b1;
        bus.Bit_Data  = 1'b0;
      end
    end
    check($sformatf("v%0d tx_start_count", id), start_cnt, 1);
    check($sformatf("v%0d tx_start_cycle", id), start_k, 1);
    check($sformatf("v%0d done_cycle", id), done_k, exp_done);
    check($sformatf("v%0d done_count", id), done_cnt, (exp_done >= 0) ? 1 : 0);
    check($sformatf("v%0d tx_input_bad_cycles", id), bad_bits, 0);
    check($sformatf("v%0d busy_bad_cycles", id), bad_busy, 0);
    check($sformatf("v%0d payload_bits_taken", id), bit_cnt,
          (exp_done >= 0) ? 8 * v.len : v.drop + 1);
    check($sformatf("v%0d symbol_count", id), sym_end, exp_sym);
    check($sformatf("v%0d underrun", id), unr_end, (v.drop >= 0) ? 1 : 0);
    check($sformatf("v%0d req_ready_at_end", id), rdy_end, (exp_done >= 0) ? 0 : 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, done1, done2, starts, rr_bad, n_acc, cyc;
    bus.Req_Valid  = 1'b0;
    bus.Req_Length = '0;
    bus.Bit_Valid  = 1'b1;
    bus.Bit_Data   = 1'b0;

    //           len  payload (MSB first)              drop sym total
    vecs[0] = '{0, 64'h0,                              -1,  1, 24};
    vecs[1] = '{1, {8'h96, 56'h0},                     -1,  2, 48};
    vecs[2] = '{3, {24'hA5C33C, 40'h0},                11,  2, 48};
    vecs[3] = '{2, {16'hF00F, 48'h0},                  -1,  2, 48};
    vecs[4] = '{5, {40'h8E5AC371F0, 24'h0},            -1,  3, 72};
    vecs[5] = '{2, {16'hFFFF, 48'h0},                   0,  2, 48};

    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset req_ready", int'(bus.Req_Ready), 1);
    check("reset tx_start", int'(bus.Tx_Start), 0);
    check("reset tx_input", int'(bus.Tx_Input), 0);
    check("reset busy", int'(bus.Busy), 0);
    check("reset done", int'(bus.Done), 0);
    check("reset underrun", int'(bus.Underrun), 0);
    check("reset symbol_count", int'(bus.Symbol_Count), 0);
    check("reset bit_ready", int'(bus.Bit_Ready), 0);

    for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

    // Reset in the middle of the payload, then a clean restart.
    bus.Req_Valid  = 1'b1;
    bus.Req_Length = 12'd2;
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    for (int w = 0; w < 300 && !bus.Bit_Ready; w++) @(negedge clk);
    check("midrst reached payload", int'(bus.Bit_Ready), 1);
    bus.Bit_Valid = 1'b1;
    bus.Bit_Data  = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst tx_input before reset", int'(bus.Tx_Input), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst tx_input", int'(bus.Tx_Input), 0);
    check("midrst busy", int'(bus.Busy), 0);
    check("midrst req_ready", int'(bus.Req_Ready), 1);
    check("midrst bit_ready", int'(bus.Bit_Ready), 0);
    check("midrst done", int'(bus.Done), 0);
    rst = 1'b0;
    bus.Bit_Data = 1'b0;
    @(negedge clk);
    run_frame(10, vecs[1]);

    // Req_Valid held high across two zero-length frames.
    acc0 = -1000; acc1 = -1000; done1 = -1000; done2 = -1000;
    starts = 0; rr_bad = 0; n_acc = 0; cyc = 0;
    bus.Req_Valid  = 1'b1;
    bus.Req_Length = 12'd0;
    for (int j = 0; j < 400; j++) begin
      if (n_acc == 2) begin
        bus.Req_Valid = 1'b0;
        break;
      end
      if (bus.Req_Ready && bus.Req_Valid) begin
        if (n_acc == 0) acc0 = cyc; else acc1 = cyc;
        n_acc++;
      end
      if (bus.Done && done1 < 0) done1 = cyc;
      if (bus.Tx_Start) starts++;
      if (bus.Busy && bus.Req_Ready) rr_bad++;
      @(negedge clk);
      cyc++;
    end
    bus.Req_Valid = 1'b0;
    for (int w = 0; w < 300 && done2 < 0; w++) begin
      if (bus.Done) done2 = cyc;
      @(negedge clk);
      cyc++;
    end
    check("b2b first done latency", done1 - acc0, 162);
    check("b2b second accept gap", acc1 - done1, 1);
    check("b2b starts in first frame", starts, 1);
    check("b2b ready while busy", rr_bad, 0);
    check("b2b second done latency", done2 - acc1, 162);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
